log_capture_ctrl: RTL and testbench

- Sequences the log memory: on a run command from the file register it captures a stream of datapath words into an internal RAM until the RAM is full, then raises mem_full.
- Afterwards it serves random-access reads at the address supplied by the file register.
- Sits between the file register outputs (run_log, read_log, addr_log) and its inputs (mem_full, data_log_from_mem).

---
 rtl/log_capture_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_log_capture_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/log_capture_ctrl.sv
// Log memory sequencer: captures a datapath stream into RAM on a run edge, then serves reads.
// Optional compile macro LOG_TRIGGER_EN adds an ARMED state that waits for i_trigger before capturing.
module log_capture_ctrl #(
  parameter int NB_LOG  = 32,
  parameter int NB_ADDR = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_run_log,
  input  logic               i_read_log,
  input  logic [NB_ADDR-1:0] i_addr_log,
  input  logic [NB_LOG-1:0]  i_log_data,
  input  logic               i_log_valid,
  input  logic               i_trigger,
  output logic               o_mem_full,
  output logic               o_capturing,
  output logic [NB_LOG-1:0]  o_data_log,
  output logic               o_data_log_valid,
  output logic [NB_ADDR:0]   o_wr_count
`ifdef LOG_TRIGGER_EN
  ,
  output logic               o_armed
`endif
);

  localparam logic [NB_ADDR-1:0] PTR_LAST = {NB_ADDR{1'b1}};
  localparam logic [NB_ADDR-1:0] PTR_ONE  = NB_ADDR'(1);
  localparam logic [NB_ADDR:0]   CNT_ONE  = (NB_ADDR + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  state_t              restart_st_s;
  logic                run_d_r;
  logic                run_rise_s;
  logic                trig_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic                capturing_nxt_s;
  logic                capturing_r;
  logic                mem_full_r;
  logic [NB_ADDR-1:0]  ptr_r;
  logic [NB_ADDR:0]    wr_count_r;
  logic [NB_LOG-1:0]   data_r;
  logic                data_valid_r;
  logic [NB_LOG-1:0]   mem_r [0:(1 << NB_ADDR) - 1];

`ifdef LOG_TRIGGER_EN
  logic armed_nxt_s;
  logic armed_r;
  assign trig_s       = i_trigger;
  assign restart_st_s = ST_ARMED;
`else
  logic unused_trigger_s;
  assign unused_trigger_s = i_trigger;
  assign trig_s           = 1'b0;
  assign restart_st_s     = ST_CAPTURE;
`endif

  assign run_rise_s = i_run_log & ~run_d_r;

  // Run level delay for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_d_r <= 1'b0;
    end else begin
      run_d_r <= i_run_log;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a run edge restarts from any state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run_rise_s) state_nxt_s = restart_st_s;
        else            state_nxt_s = ST_IDLE;
      end
      ST_ARMED: begin
        if (run_rise_s)  state_nxt_s = restart_st_s;
        else if (trig_s) state_nxt_s = ST_CAPTURE;
        else             state_nxt_s = ST_ARMED;
      end
      ST_CAPTURE: begin
        if (run_rise_s)                             state_nxt_s = restart_st_s;
        else if (i_log_valid && (ptr_r == PTR_LAST)) state_nxt_s = ST_FULL;
        else                                        state_nxt_s = ST_CAPTURE;
      end
      ST_FULL: begin
        if (run_rise_s) state_nxt_s = restart_st_s;
        else            state_nxt_s = ST_FULL;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM output decode: write/read enables and next-cycle status flags
  always_comb begin
    wr_en_s         = 1'b0;
    rd_en_s         = 1'b0;
    capturing_nxt_s = 1'b0;
    // The restart wins over a coincident valid word
    if (run_rise_s) begin
      wr_en_s = 1'b0;
    end else if (state_r == ST_CAPTURE) begin
      wr_en_s = i_log_valid;
    end else if (state_r == ST_ARMED) begin
      wr_en_s = i_log_valid & trig_s;
    end else begin
      wr_en_s = 1'b0;
    end
    if (i_read_log && (state_r != ST_CAPTURE)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    capturing_nxt_s = (state_nxt_s == ST_CAPTURE);
`ifdef LOG_TRIGGER_EN
    armed_nxt_s = (state_nxt_s == ST_ARMED);
`endif
  end

  // Registered status flags derived from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      capturing_r <= 1'b0;
      mem_full_r  <= 1'b0;
    end else begin
      capturing_r <= capturing_nxt_s;
      mem_full_r  <= (state_nxt_s == ST_FULL);
    end
  end

`ifdef LOG_TRIGGER_EN
  // Armed flag register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= armed_nxt_s;
    end
  end
  assign o_armed = armed_r;
`endif

  // Write pointer and word counter; the pointer wraps to 0 on the last write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r      <= '0;
      wr_count_r <= '0;
    end else if (run_rise_s) begin
      ptr_r      <= '0;
      wr_count_r <= '0;
    end else if (wr_en_s) begin
      ptr_r      <= ptr_r + PTR_ONE;
      wr_count_r <= wr_count_r + CNT_ONE;
    end else begin
      ptr_r      <= ptr_r;
      wr_count_r <= wr_count_r;
    end
  end

  // Capture RAM write port; contents are intentionally not reset
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[ptr_r] <= i_log_data;
    end
  end

  // Registered read port; data holds when no read is granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_r       <= '0;
      data_valid_r <= 1'b0;
    end else if (rd_en_s) begin
      data_r       <= mem_r[i_addr_log];
      data_valid_r <= 1'b1;
    end else begin
      data_r       <= data_r;
      data_valid_r <= 1'b0;
    end
  end

  assign o_mem_full       = mem_full_r;
  assign o_capturing      = capturing_r;
  assign o_wr_count       = wr_count_r;
  assign o_data_log       = data_r;
  assign o_data_log_valid = data_valid_r;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Bench for log_capture_ctrl (depth 16): directed scenarios plus random traffic against a queue-free array model.
module tb_log_capture_ctrl;
  localparam int NB_LOG  = 32;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;
`ifdef LOG_TRIGGER_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_ARM = 1, M_CAP = 2, M_FULL = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               i_run_log = 1'b0;
  logic               i_read_log = 1'b0;
  logic [NB_ADDR-1:0] i_addr_log = '0;
  logic [NB_LOG-1:0]  i_log_data = '0;
  logic               i_log_valid = 1'b0;
  logic               i_trigger = 1'b0;
  logic               o_mem_full;
  logic               o_capturing;
  logic [NB_LOG-1:0]  o_data_log;
  logic               o_data_log_valid;
  logic [NB_ADDR:0]   o_wr_count;
`ifdef LOG_TRIGGER_EN
  logic               o_armed;
`endif

  log_capture_ctrl #(.NB_LOG(NB_LOG), .NB_ADDR(NB_ADDR)) dut (
    .clock(clock), .reset(reset), .i_run_log(i_run_log), .i_read_log(i_read_log),
    .i_addr_log(i_addr_log), .i_log_data(i_log_data), .i_log_valid(i_log_valid),
    .i_trigger(i_trigger), .o_mem_full(o_mem_full), .o_capturing(o_capturing),
    .o_data_log(o_data_log), .o_data_log_valid(o_data_log_valid), .o_wr_count(o_wr_count)
`ifdef LOG_TRIGGER_EN
    , .o_armed(o_armed)
`endif
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  int           m_mode;
  int           m_count;
  bit           m_prev_run;
  logic [31:0]  m_mem [DEPTH];
  bit           m_known [DEPTH];
  bit           m_valid;
  logic [31:0]  m_data;
  bit           m_data_known;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_count = 0; m_prev_run = 1'b0;
    m_valid = 1'b0; m_data = '0; m_data_known = 1'b1;
  endtask

  task automatic model_write(input logic [31:0] data);
    m_mem[m_count]   = data;
    m_known[m_count] = 1'b1;
    m_count++;
  endtask

  task automatic model_step(input bit run, input bit valid, input bit rd, input bit trig,
                            input int addr, input logic [31:0] data);
    bit rise;
    rise = run && !m_prev_run;
    m_prev_run = run;
    if (rd && m_mode != M_CAP) begin
      m_valid = 1'b1; m_data = m_mem[addr]; m_data_known = m_known[addr];
    end else begin
      m_valid = 1'b0;
    end
    if (rise) begin
      m_mode = TRIG_EN ? M_ARM : M_CAP;
      m_count = 0;
    end else if (m_mode == M_CAP && valid) begin
      model_write(data);
      if (m_count == DEPTH) m_mode = M_FULL;
    end else if (m_mode == M_ARM && trig) begin
      if (valid) model_write(data);
      m_mode = M_CAP;
    end
  endtask

  task automatic compare_all();
    check_val("capturing", o_capturing, m_mode == M_CAP);
    check_val("mem_full", o_mem_full, m_mode == M_FULL);
    check_val("wr_count", o_wr_count, m_count);
    check_val("rd_valid", o_data_log_valid, m_valid);
    if (m_data_known) check_val("rd_data", o_data_log, m_data);
`ifdef LOG_TRIGGER_EN
    check_val("armed", o_armed, m_mode == M_ARM);
`endif
  endtask

  task automatic cyc(input bit run, input bit valid, input bit rd, input bit trig,
                     input int addr, input logic [31:0] data);
    i_run_log = run; i_log_valid = valid; i_read_log = rd; i_trigger = trig;
    i_addr_log = addr[NB_ADDR-1:0]; i_log_data = data;
    @(posedge clock);
    #1;
    model_step(run, valid, rd, trig, addr, data);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_known[i] = 1'b0; m_mem[i] = '0; end
    model_reset();
    #2 reset = 1'b1;
    #3;
    check_val("rst_capturing", o_capturing, 1'b0);
    check_val("rst_full", o_mem_full, 1'b0);
    check_val("rst_count", o_wr_count, 0);
    check_val("rst_valid", o_data_log_valid, 1'b0);
    check_val("rst_data", o_data_log, 0);
    @(posedge clock); #1; reset = 1'b0;

    // full capture of 100..115 after a one-cycle run pulse
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 1, 0, 100 + i);
    check_val("t1_full", o_mem_full, 1'b1);
    check_val("t1_count", o_wr_count, 16);
    check_val("t1_capturing", o_capturing, 1'b0);

    // random-access reads after capture
    cyc(0, 0, 1, 0, 0, 0);  check_val("t2_rd0", o_data_log, 100);
    cyc(0, 0, 1, 0, 5, 0);  check_val("t2_rd5", o_data_log, 105);
    cyc(0, 0, 1, 0, 15, 0); check_val("t2_rd15", o_data_log, 115);
    check_val("t2_valid", o_data_log_valid, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);

    // run held high through and beyond a capture: no re-trigger
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 1, 0, 500 + i);
    for (int i = 0; i < 40; i++) cyc(1, 1, 0, 1, 0, 600 + i);
    check_val("t3_still_full", o_mem_full, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check_val("t3_restart_full", o_mem_full, 1'b0);
    check_val("t3_restart_count", o_wr_count, 0);

    // gapped valid with reads attempted during capture
    for (int i = 0; i < 10; i++) cyc(0, (i % 2) == 0, 1, 1, i, 7);
    check_val("t4_count", o_wr_count, 5);
    check_val("t4_rd_blocked", o_data_log_valid, 1'b0);
    for (int i = 0; i < 11; i++) cyc(0, 1, 0, 0, 0, 700 + i);

    // async reset mid-capture, then a fresh run from address 0
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 1, 0, 300 + i);
    reset = 1'b1;
    #1;
    check_val("t5_capturing", o_capturing, 1'b0);
    check_val("t5_full", o_mem_full, 1'b0);
    check_val("t5_count", o_wr_count, 0);
    model_reset();
    @(posedge clock); #1; reset = 1'b0;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 1, 0, 200 + i);
    cyc(0, 0, 1, 0, 0, 0);
    check_val("t5_rd0", o_data_log, 200);

`ifdef LOG_TRIGGER_EN
    // armed wait, then trigger writes the first word
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, (i % 2) == 1, 0, 0, 0, 900 + i);
    check_val("t6_armed", o_armed, 1'b1);
    check_val("t6_count", o_wr_count, 0);
    cyc(0, 1, 0, 1, 0, 55);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0, 800 + i);
    cyc(0, 0, 1, 0, 0, 0);
    check_val("t6_rd0", o_data_log, 55);
`endif

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, $urandom_range(0, DEPTH - 1), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
